// File: rtl/cpstr_man_rx_pkg.sv
// Shared constants and types for the cpstr receive path.
// Holds the escape character, the select-code rule and the decoder state encoding.
package cpstr_man_rx_pkg;

    localparam logic [7:0] ESC_CHAR    = 8'd27;
    localparam int         MAX_STREAMS = 27;

    typedef enum logic {
        S_DATA = 1'b0,
        S_ESC  = 1'b1
    } rx_state_e;

    // A byte following ESC selects a stream only if it names an existing one.
    function automatic logic is_select(input logic [7:0] b, input int num_streams);
        return (int'(b) < num_streams) && (num_streams <= MAX_STREAMS);
    endfunction

endpackage

// File: rtl/cpstr_hold_reg.sv
// One-entry tagged holding register with load/drain and pass-through ready.
// Latency: load -> full on the next cycle.
// Backpressure: pass_rdy = ~full | drain_rdy, so a draining entry can be replaced in the same cycle.
module cpstr_hold_reg #(
    parameter int DW = 8,
    parameter int TW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_dat,
    input  logic [TW-1:0] load_tag,
    input  logic          drain_rdy,
    output logic          full,
    output logic [DW-1:0] hold_dat,
    output logic [TW-1:0] hold_tag,
    output logic          pass_rdy
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full     <= 1'b0;
            hold_dat <= '0;
            hold_tag <= '0;
        end else if (load) begin
            full     <= 1'b1;
            hold_dat <= load_dat;
            hold_tag <= load_tag;
        end else if (drain_rdy) begin
            full     <= 1'b0;
        end
    end

    assign pass_rdy = ~full | drain_rdy;

endmodule

// File: rtl/cpstr_man_rx.sv
// Escaped cpstr byte stream demultiplexer onto NUM_STREAMS valid/ready ports.
// Latency: accepted data byte -> o_valid on the next cycle; 1 byte/clk sustained.
// Backpressure: any stalled stream blocks data bytes for all; ESC/select bytes pass while full.
module cpstr_man_rx
    import cpstr_man_rx_pkg::*;
#(
    parameter  int NUM_STREAMS = 3,
    localparam int IDXW        = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [8*NUM_STREAMS-1:0] o_data,
    output logic [NUM_STREAMS-1:0]   o_valid,
    input  logic [NUM_STREAMS-1:0]   i_ready,
    output logic [IDXW-1:0]          o_stridx,
    output logic                     o_sel_valid,
    output logic                     o_err
);

    rx_state_e       state, state_nxt;
    logic [IDXW-1:0] stridx;
    logic            sel_valid;
    logic            err_q;

    logic            want_load, err_case, sel_case, accept;
    logic            hold_full, hold_rdy, drain_rdy;
    logic [7:0]      hold_dat;
    logic [IDXW-1:0] hold_tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_DATA;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_DATA:  if (i_data == ESC_CHAR) state_nxt = S_ESC;
                S_ESC:   state_nxt = S_DATA;
                default: state_nxt = S_DATA;
            endcase
        end
    end

    // Only bytes that load the holding register wait on it; everything else is consumed freely.
    always_comb begin
        want_load = 1'b0;
        err_case  = 1'b0;
        sel_case  = 1'b0;
        case (state)
            S_DATA: begin
                if (i_data != ESC_CHAR) begin
                    if (sel_valid) want_load = 1'b1;
                    else           err_case  = 1'b1;
                end
            end
            S_ESC: begin
                if (i_data == ESC_CHAR) begin
                    if (sel_valid) want_load = 1'b1;
                    else           err_case  = 1'b1;
                end else if (is_select(i_data, NUM_STREAMS)) begin
                    sel_case = 1'b1;
                end else begin
                    err_case = 1'b1;
                end
            end
            default: err_case = 1'b0;
        endcase
        o_ready = want_load ? hold_rdy : 1'b1;
        accept  = i_valid & o_ready;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stridx    <= '0;
            sel_valid <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept & err_case;
            if (accept & sel_case) begin
                stridx    <= i_data[IDXW-1:0];
                sel_valid <= 1'b1;
            end
        end
    end

    cpstr_hold_reg #(
        .DW (8),
        .TW (IDXW)
    ) u_hold (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .load      (accept & want_load),
        .load_dat  (i_data),
        .load_tag  (stridx),
        .drain_rdy (drain_rdy),
        .full      (hold_full),
        .hold_dat  (hold_dat),
        .hold_tag  (hold_tag),
        .pass_rdy  (hold_rdy)
    );

    // The held byte keeps its own tag, so a later select never redirects it.
    always_comb begin
        o_valid = '0;
        o_data  = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            o_valid[k]       = hold_full && (hold_tag == IDXW'(k));
            o_data[8*k +: 8] = hold_dat;
        end
    end

    assign drain_rdy   = |(o_valid & i_ready);
    assign o_stridx    = stridx;
    assign o_sel_valid = sel_valid;
    assign o_err       = err_q;

endmodule

// File: tb/tb_cpstr_man_rx.sv
// Bench for cpstr_man_rx: directed protocol cases plus randomized traffic against a stream decoder model.
module tb_cpstr_man_rx;

    localparam int NS = 3;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [7:0]      i_data;
    logic            i_valid;
    logic            o_ready;
    logic [8*NS-1:0] o_data;
    logic [NS-1:0]   o_valid;
    logic [NS-1:0]   i_ready;
    logic [1:0]      o_stridx;
    logic            o_sel_valid;
    logic            o_err;

    int vectors     = 0;
    int miscompares = 0;
    int err_cnt     = 0;
    int model_sel   = -1;
    logic rand_mode = 1'b0;

    logic [15:0] got_q[$];
    logic [7:0]  tx_q[$];

    cpstr_man_rx #(.NUM_STREAMS(NS)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_stridx    (o_stridx),
        .o_sel_valid (o_sel_valid),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Output monitor: collects delivered (stream, byte) pairs and error pulses.
    logic [NS-1:0]   prev_vld;
    logic [8*NS-1:0] prev_dat;
    logic            prev_stall = 1'b0;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                assert (o_valid === prev_vld && o_data === prev_dat) else begin
                    miscompares++;
                    $error("FAIL stall_stable got %h/%h exp %h/%h", o_valid, o_data, prev_vld, prev_dat);
                end
            end
            vectors++;
            assert ($countones(o_valid) <= 1) else begin
                miscompares++;
                $error("FAIL onehot got %b exp at most one bit", o_valid);
            end
            for (int k = 0; k < NS; k++)
                if (o_valid[k] && i_ready[k]) got_q.push_back({8'(k), o_data[8*k +: 8]});
            if (o_err === 1'b1) err_cnt++;
            prev_stall = |(o_valid & ~i_ready);
            prev_vld   = o_valid;
            prev_dat   = o_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns aligned to posedge+1.
    task automatic send(input logic [7:0] b, output int waited);
        waited  = 0;
        i_data  = b;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (o_ready !== 1'b1 && waited < 300) begin
            waited++;
            @(posedge i_clk);
            #1;
            if (rand_mode) i_ready = NS'($urandom);
            @(negedge i_clk);
        end
        chk("send_timeout", 32'(waited < 300), 32'd1);
        if (o_ready === 1'b1) tx_q.push_back(b);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        if (rand_mode) i_ready = NS'($urandom);
    endtask

    // Decodes everything sent since the last check and compares with what came out.
    task automatic check_out(input string name);
        int          n;
        int          i;
        int          exp_err;
        logic [7:0]  b;
        logic [7:0]  b2;
        logic [15:0] exp_q[$];
        n       = 0;
        i       = 0;
        exp_err = 0;
        i_ready = '1;
        @(negedge i_clk);
        while (o_valid !== '0 && n < 300) begin
            n++;
            @(negedge i_clk);
        end
        chk({name, "_drain"}, 32'(n < 300), 32'd1);
        repeat (2) @(negedge i_clk);
        while (i < tx_q.size()) begin
            b = tx_q[i];
            if (b == 8'd27 && i + 1 < tx_q.size()) begin
                b2 = tx_q[i+1];
                i += 2;
                if (b2 == 8'd27) begin
                    if (model_sel < 0) exp_err++;
                    else exp_q.push_back({8'(model_sel), 8'd27});
                end else if (int'(b2) < NS) begin
                    model_sel = int'(b2);
                end else begin
                    exp_err++;
                end
            end else if (b == 8'd27) begin
                i++;
            end else begin
                if (model_sel < 0) exp_err++;
                else exp_q.push_back({8'(model_sel), b});
                i++;
            end
        end
        chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            chk({name, "_byte"}, 32'(got_q[j]), 32'(exp_q[j]));
        chk({name, "_err"}, 32'(err_cnt), 32'(exp_err));
        got_q.delete();
        tx_q.delete();
        err_cnt = 0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_model();
        model_sel = -1;
        tx_q.delete();
        got_q.delete();
        err_cnt = 0;
    endtask

    initial begin
        int         w;
        int         r;
        logic [7:0] rb;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_ready = '1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid_in_reset", 32'(o_valid), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_stridx", 32'(o_stridx), 32'd0);
        chk("rst_sel_valid", 32'(o_sel_valid), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;

        // 1: select 0 and two data bytes
        send(8'h1B, w); send(8'h00, w); send(8'h05, w); send(8'h06, w);
        check_out("t1");
        chk("t1_stridx", 32'(o_stridx), 32'd0);
        chk("t1_sel_valid", 32'(o_sel_valid), 32'd1);

        // 2: literal escape inside back-to-back traffic
        send(8'h1B, w); chk("t2_b2b", 32'(w), 32'd0);
        send(8'h01, w); chk("t2_b2b", 32'(w), 32'd0);
        send(8'h0A, w); chk("t2_b2b", 32'(w), 32'd0);
        send(8'h1B, w); chk("t2_b2b", 32'(w), 32'd0);
        send(8'h1B, w); chk("t2_b2b", 32'(w), 32'd0);
        send(8'h0B, w); chk("t2_b2b", 32'(w), 32'd0);
        check_out("t2");
        chk("t2_stridx", 32'(o_stridx), 32'd1);

        // 3: data before any selection
        i_rst_n = 1'b0;
        #2;
        clear_model();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        send(8'h07, w); send(8'h1B, w); send(8'h02, w); send(8'h08, w);
        check_out("t3");
        chk("t3_stridx", 32'(o_stridx), 32'd2);

        // 4: invalid select code
        send(8'h1B, w); send(8'h00, w); send(8'h1B, w); send(8'h05, w); send(8'h09, w);
        check_out("t4");

        // 5: sink 1 stalled for 10 cycles
        send(8'h1B, w); send(8'h01, w);
        i_ready = 3'b101;
        send(8'h10, w);
        i_data  = 8'h11;
        i_valid = 1'b1;
        repeat (10) begin
            @(negedge i_clk);
            chk("t5_valid", 32'(o_valid), 32'b010);
            chk("t5_data", 32'(o_data[15:8]), 32'h10);
            chk("t5_ready", 32'(o_ready), 32'd0);
        end
        @(posedge i_clk);
        #1;
        i_ready = '1;
        send(8'h11, w); send(8'h12, w);
        check_out("t5");

        // 6: select while a byte is held for another stream
        send(8'h1B, w); send(8'h00, w);
        i_ready = 3'b110;
        send(8'h20, w);
        send(8'h1B, w); chk("t6_esc_pass", 32'(w), 32'd0);
        send(8'h02, w); chk("t6_sel_pass", 32'(w), 32'd0);
        @(negedge i_clk);
        chk("t6_valid", 32'(o_valid), 32'b001);
        chk("t6_data", 32'(o_data[7:0]), 32'h20);
        chk("t6_stridx", 32'(o_stridx), 32'd2);
        @(posedge i_clk);
        #1;
        i_ready = '1;
        send(8'h21, w);
        check_out("t6");

        // Reset with a held byte and a half-received escape
        send(8'h1B, w); send(8'h01, w);
        i_ready = '0;
        send(8'h33, w);
        send(8'h1B, w);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_stridx", 32'(o_stridx), 32'd0);
        chk("rst_mid_sel", 32'(o_sel_valid), 32'd0);
        clear_model();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = '1;
        send(8'h02, w);
        check_out("rst_mid");

        // Randomized traffic with random sink stalls
        rand_mode = 1'b1;
        for (int round = 0; round < 3; round++) begin
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 9);
                if (r < 3)      rb = 8'd27;
                else if (r < 5) rb = 8'($urandom_range(0, 4));
                else            rb = 8'($urandom_range(0, 255));
                send(rb, w);
            end
            send(8'h41, w);
            check_out("rand");
        end
        rand_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
